// File: rtl/jogo_memoria_param.sv
// Parametrised memory-sequence game: replays an LFSR-generated sequence on the
// LEDs each round, then checks the player's presses with a per-move timeout.
module jogo_memoria_param #(
    parameter int         N_BOTOES    = 4,
    parameter int         MAX_SEQ     = 16,
    parameter int         TIMEOUT     = 3000,
    parameter int         SHOW_CYCLES = 500,
    parameter logic [7:0] SEED        = 8'h01,
    parameter int         ALEATORIO   = 0
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      jogar,
    input  logic [N_BOTOES-1:0]       botoes,
    input  logic [1:0]                nivel,
    output logic                      ganhou,
    output logic                      perdeu,
    output logic                      pronto,
    output logic [N_BOTOES-1:0]       leds,
    output logic [3:0]                db_estado,
    output logic [$clog2(MAX_SEQ):0]  db_rodada,
    output logic [N_BOTOES-1:0]       db_jogada,
    output logic                      db_timeout
);

    localparam int         LB    = $clog2(N_BOTOES);
    localparam int         RW    = $clog2(MAX_SEQ) + 1;
    localparam int         SW    = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
    localparam int         TW    = $clog2(TIMEOUT);
    localparam logic [7:0] SEED0 = (SEED == 8'h00) ? 8'h01 : SEED;

    typedef enum logic [3:0] {
        S_INICIAL     = 4'd0,
        S_PREPARA     = 4'd1,
        S_MOSTRA      = 4'd2,
        S_APAGA       = 4'd3,
        S_ESPERA      = 4'd4,
        S_COMPARA     = 4'd5,
        S_PROX_JOGADA = 4'd6,
        S_PROX_RODADA = 4'd7,
        S_GANHOU      = 4'd10,
        S_PERDEU      = 4'd14
    } estado_t;

    estado_t              estado;
    logic [RW-1:0]        rodada, k, alvo;
    logic [SW-1:0]        cnt_show;
    logic [TW-1:0]        cnt_to;
    logic [7:0]           lfsr_free, lfsr_jogo, seed_jogo;
    logic [N_BOTOES-1:0]  botoes_d;
    logic                 evento;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic logic [N_BOTOES-1:0] onehot(input logic [LB-1:0] idx);
        return {{(N_BOTOES-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Rising edge of "any button"; a button held across states never re-fires.
    assign evento    = (botoes != '0) && (botoes_d == '0);
    assign db_estado = estado;
    assign db_rodada = rodada;

    // NOTE: every register here uses <=, so branches that read k or lfsr_jogo
    // see the value from before this edge even when they also update it.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado     <= S_INICIAL;
            rodada     <= '0;
            k          <= '0;
            alvo       <= '0;
            cnt_show   <= '0;
            cnt_to     <= '0;
            lfsr_free  <= SEED0;
            lfsr_jogo  <= SEED0;
            seed_jogo  <= SEED0;
            botoes_d   <= '0;
            db_jogada  <= '0;
            db_timeout <= 1'b0;
            ganhou     <= 1'b0;
            perdeu     <= 1'b0;
            pronto     <= 1'b0;
            leds       <= '0;
        end else begin
            lfsr_free <= lfsr_next(lfsr_free);
            botoes_d  <= botoes;
            case (estado)
                S_INICIAL, S_GANHOU, S_PERDEU: begin
                    if (jogar) begin
                        if (ALEATORIO != 0) seed_jogo <= lfsr_free;
                        ganhou <= 1'b0;
                        perdeu <= 1'b0;
                        pronto <= 1'b0;
                        estado <= S_PREPARA;
                    end
                end
                S_PREPARA: begin
                    alvo       <= RW'((int'(nivel) + 1) * (MAX_SEQ / 4));
                    rodada     <= RW'(1);
                    k          <= '0;
                    lfsr_jogo  <= seed_jogo;
                    cnt_show   <= '0;
                    db_timeout <= 1'b0;
                    db_jogada  <= '0;
                    leds       <= onehot(seed_jogo[LB-1:0]);
                    estado     <= S_MOSTRA;
                end
                S_MOSTRA: begin
                    if (cnt_show == SW'(SHOW_CYCLES - 1)) begin
                        cnt_show <= '0;
                        leds     <= '0;
                        estado   <= S_APAGA;
                    end else begin
                        cnt_show <= cnt_show + 1'b1;
                    end
                end
                S_APAGA: begin
                    if (cnt_show == SW'(SHOW_CYCLES - 1)) begin
                        cnt_show <= '0;
                        if (k + 1'b1 == rodada) begin
                            k         <= '0;
                            lfsr_jogo <= seed_jogo;
                            cnt_to    <= '0;
                            estado    <= S_ESPERA;
                        end else begin
                            k         <= k + 1'b1;
                            lfsr_jogo <= lfsr_next(lfsr_jogo);
                            leds      <= onehot(lfsr_next(lfsr_jogo)[LB-1:0]);
                            estado    <= S_MOSTRA;
                        end
                    end else begin
                        cnt_show <= cnt_show + 1'b1;
                    end
                end
                S_ESPERA: begin
                    // A press in the expiry cycle still counts as a move.
                    if (evento) begin
                        db_jogada <= botoes;
                        estado    <= S_COMPARA;
                    end else if (cnt_to == TW'(TIMEOUT - 1)) begin
                        db_timeout <= 1'b1;
                        perdeu     <= 1'b1;
                        pronto     <= 1'b1;
                        estado     <= S_PERDEU;
                    end else begin
                        cnt_to <= cnt_to + 1'b1;
                    end
                end
                S_COMPARA: begin
                    if (db_jogada == onehot(lfsr_jogo[LB-1:0])) begin
                        estado <= S_PROX_JOGADA;
                    end else begin
                        perdeu <= 1'b1;
                        pronto <= 1'b1;
                        estado <= S_PERDEU;
                    end
                end
                S_PROX_JOGADA: begin
                    if (k < rodada - 1'b1) begin
                        k         <= k + 1'b1;
                        lfsr_jogo <= lfsr_next(lfsr_jogo);
                        cnt_to    <= '0;
                        estado    <= S_ESPERA;
                    end else if (rodada == alvo) begin
                        ganhou <= 1'b1;
                        pronto <= 1'b1;
                        estado <= S_GANHOU;
                    end else begin
                        estado <= S_PROX_RODADA;
                    end
                end
                S_PROX_RODADA: begin
                    rodada    <= rodada + 1'b1;
                    k         <= '0;
                    lfsr_jogo <= seed_jogo;
                    cnt_show  <= '0;
                    leds      <= onehot(seed_jogo[LB-1:0]);
                    estado    <= S_MOSTRA;
                end
                default: estado <= S_INICIAL;
            endcase
        end
    end

endmodule
